// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU pipeline constants and hazard helpers.
// Used by the hazard controller and its HI/LO timer.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE  = 2'd3;

  localparam logic [1:0] FWD_D_GRF  = 2'd0;
  localparam logic [1:0] FWD_D_E    = 2'd1;
  localparam logic [1:0] FWD_D_M    = 2'd2;

  localparam logic [1:0] FWD_E_PIPE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } stage_t;

  function automatic logic src_hazard(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input stage_t     e,
    input stage_t     m
  );
    return (r != 5'd0) && (tuse != TUSE_NONE) &&
           ((e.dst == r && e.tnew > tuse) ||
            (m.dst == r && m.tnew > tuse));
  endfunction

  function automatic logic [1:0] fwd_d(
    input logic [4:0] r,
    input stage_t     e,
    input stage_t     m
  );
    if (r == 5'd0)
      return FWD_D_GRF;
    if (e.dst == r && e.tnew == 2'd0)
      return FWD_D_E;
    if (m.dst == r && m.tnew == 2'd0)
      return FWD_D_M;
    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [4:0] r,
    input stage_t     m,
    input logic [4:0] w_dst
  );
    if (r == 5'd0)
      return FWD_E_PIPE;
    if (m.dst == r && m.tnew == 2'd0)
      return FWD_E_M;
    if (w_dst == r)
      return FWD_E_W;
    return FWD_E_PIPE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// HI/LO busy timer: loaded when a mult/div issues into E,
// counts down to zero while the unit is busy.
module hz_md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_div,
  output logic o_busy
);

  localparam int MAXC =
    (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (r_cnt != '0)
      r_cnt <= r_cnt - CW'(1);
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall on unready operands or busy HI/LO,
// forward select for D and E operands.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       md_busy
);

  stage_t     r_e;
  stage_t     r_m;
  logic [4:0] r_e_rs;
  logic [4:0] r_e_rt;
  logic [4:0] r_w_dst;

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_md_stall;
  logic w_stall;
  logic w_md_load;
  logic w_busy;

  assign w_hz_rs = src_hazard(d_rs, d_tuse_rs, r_e, r_m);
  assign w_hz_rt = src_hazard(d_rt, d_tuse_rt, r_e, r_m);

  assign w_md_stall = d_valid & (d_md_start | d_md_use) & w_busy;
  assign w_stall    = w_hz_rs | w_hz_rt | w_md_stall;
  assign w_md_load  = d_valid & d_md_start & ~w_stall;

  // stalled or empty D slot enters E as a full bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e     <= '0;
      r_m     <= '0;
      r_e_rs  <= '0;
      r_e_rt  <= '0;
      r_w_dst <= '0;
    end else begin
      if (w_stall || !d_valid) begin
        r_e    <= '0;
        r_e_rs <= '0;
        r_e_rt <= '0;
      end else begin
        r_e    <= '{dst: d_dst, tnew: d_tnew};
        r_e_rs <= d_rs;
        r_e_rt <= d_rt;
      end
      r_m.dst  <= r_e.dst;
      r_m.tnew <= (r_e.tnew != 2'd0) ? r_e.tnew - 2'd1 : 2'd0;
      r_w_dst  <= r_m.dst;
    end
  end

  hz_md_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .i_load(w_md_load),
    .i_div (d_md_div),
    .o_busy(w_busy)
  );

  assign stall    = w_stall;
  assign md_busy  = w_busy;
  assign fwd_rs_d = fwd_d(d_rs, r_e, r_m);
  assign fwd_rt_d = fwd_d(d_rt, r_e, r_m);
  assign fwd_rs_e = fwd_e(r_e_rs, r_m, r_w_dst);
  assign fwd_rt_e = fwd_e(r_e_rt, r_m, r_w_dst);

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, HI/LO busy cycles after a multiply enters E.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, HI/LO busy cycles after a divide enters E.
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port d_valid  in  1  D-stage instruction valid.
REQ-006 SHALL have ports d_rs, d_rt  in  5 each  D-stage source register numbers.
REQ-007 SHALL have ports d_tuse_rs, d_tuse_rt  in  2 each  cycles until operand consumed; 0 = D, 1 = E, 2 = M, 3 = not used.
REQ-008 SHALL have port d_dst  in  5  destination register; 0 = no write.
REQ-009 SHALL have port d_tnew  in  2  cycles after entering E until result exists; 0 = link/constant, 1 = ALU, 2 = load.
REQ-010 SHALL have ports d_md_start, d_md_div, d_md_use  in  1 each  mult/div start, divide select, HI/LO access.
REQ-011 SHALL have port stall  out  1  freeze PC and F/D register, insert bubble into E.
REQ-012 SHALL have ports fwd_rs_d, fwd_rt_d  out  2 each  D forward select; 0 = GRF, 1 = E result, 2 = M result.
REQ-013 SHALL have ports fwd_rs_e, fwd_rt_e  out  2 each  E forward select; 0 = pipeline register, 1 = M result, 2 = W result.
REQ-014 SHALL have port md_busy  out  1  HI/LO unit busy.

Function
REQ-015 SHALL hold per-stage records E, M and W of {dst, tnew}; E also holds {rs, rt}.
REQ-016 SHALL, each clock when not stalled, load E from D ({d_dst, d_tnew, d_rs, d_rt}), or a bubble (dst = 0) when d_valid = 0.
REQ-017 SHALL, each clock when stalled, load E with a bubble (dst = 0, tnew = 0, rs = rt = 0).
REQ-018 SHALL advance E to M every clock with tnew = max(E.tnew - 1, 0), and M to W every clock with tnew = 0.
REQ-019 SHALL raise stall combinationally when, for rs or rt with reg != 0 and tuse != 3: (E.dst == reg and E.tnew > tuse) or (M.dst == reg and M.tnew > tuse).
REQ-020 SHALL NOT stall on a W-stage match; the GRF write-through bypass covers it.
REQ-021 SHALL raise stall when d_valid, (d_md_start or d_md_use), and md_busy = 1.
REQ-022 SHALL set fwd_*_d to 1 when E.dst == reg != 0 and E.tnew == 0, else 2 when M.dst == reg != 0 and M.tnew == 0, else 0; the E match has priority over the M match.
REQ-023 SHALL set fwd_*_e, using E.rs/E.rt, to 1 when M.dst == reg != 0 and M.tnew == 0, else 2 when W.dst == reg != 0, else 0.
REQ-024 SHALL force every forward select to 0 for register 0.
REQ-025 SHALL load the busy counter with DIV_CYCLES (d_md_div = 1) or MULT_CYCLES when d_valid, d_md_start and not stalled, at that clock edge.
REQ-026 SHALL otherwise decrement a nonzero busy counter by 1 per clock; md_busy = (counter != 0).
REQ-027 SHALL size the busy counter for DIV_CYCLES without wrap; the decrement saturates at 0.

Reset
REQ-028 SHALL clear all stage records, E sources and the busy counter on reset.
REQ-029 SHALL then drive stall = 0, md_busy = 0 and all fwd_* = 0 in the cycle after reset.
REQ-030 SHALL let reset abort any pending stall or busy count immediately, taking priority over all updates.

Structure
REQ-031 SHALL place TUSE_NONE = 3, FWD_* encodings and MULT_CYCLES/DIV_CYCLES defaults in the shared CPU constants package.
REQ-032 SHALL implement the HI/LO busy counter as sub-module hz_md_timer; stage records stay inline.

Verification
REQ-033 SHALL cover load-use: load $8 (tnew 2) then D reads $8 with tuse 1 -> stall = 1 for exactly 1 cycle, then fwd_rs_e = 2 (W).
REQ-034 SHALL cover ALU-to-branch: ALU writes $9 (tnew 1), next D reads $9 with tuse 0 -> stall 1 cycle, then fwd_rs_d = 2 (M).
REQ-035 SHALL cover priority: $5 written by both E (tnew 0) and M (tnew 0), D reads $5 -> fwd_rs_d = 1.
REQ-036 SHALL cover register 0: E.dst = 0 with tnew 2, D reads $0 with tuse 0 -> stall = 0, fwd = 0.
REQ-037 SHALL cover divide: div enters E, then mfhi in D -> md_busy high 10 cycles, stall high during them, mfhi proceeds on cycle 11.
REQ-038 SHALL cover reset: reset asserted mid-divide (counter = 4) -> md_busy = 0 and stall = 0 next cycle.
